serial_pwd_unlock: RTL and testbench

Parametrised serial password checker, the next generation of the fixed-pattern Mealy unlock FSM. It accepts a serial bitstream one bit per valid/ready handshake and groups the bits into frames of PWD_LEN bits. At the end of each frame it pulses either `unlock` or `pwd_incorrect`. It adds a runtime-loadable password and an optional attempt-limit lockout, and sits between the serial front end and the lock actuator logic.

---
 rtl/serial_unlock_pkg.sv | 27 ++
 rtl/serial_unlock_lockout_timer.sv | 28 ++
 rtl/serial_pwd_unlock.sv | 162 ++++++++++++++++
 tb/tb_serial_pwd_unlock.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_unlock_pkg.sv
// Shared types and width helpers for the serial password unlock block.
package serial_unlock_pkg;

    // Frame-level controller states; LOCKOUT is only reachable when the
    // attempt-limit feature is built in.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOCKOUT = 2'd2
    } unlock_state_t;

    // Bit index inside a frame spans 0 .. pwd_len-1.
    function automatic int bit_cnt_width(input int pwd_len);
        return (pwd_len < 2) ? 1 : $clog2(pwd_len);
    endfunction

    // Failed-attempt counter must be able to hold max_attempts itself.
    function automatic int attempt_width(input int max_attempts);
        return (max_attempts < 1) ? 1 : $clog2(max_attempts + 1);
    endfunction

    // Lockout timer holds lockout_cycles-1 down to 0.
    function automatic int timer_width(input int lockout_cycles);
        return (lockout_cycles < 2) ? 1 : $clog2(lockout_cycles);
    endfunction

endpackage

// File: rtl/serial_unlock_lockout_timer.sv
// Load/decrement down-counter used to time the lockout window.
// done is high whenever the count has reached zero.
module serial_unlock_lockout_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] r_count;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/serial_pwd_unlock.sv
// Serial password checker: collects PWD_LEN bits per frame (MSB first) and
// pulses unlock or pwd_incorrect combinationally on the last handshake.
// Optional attempt-limit lockout is enabled by defining SERIAL_UNLOCK_LOCKOUT_EN.
module serial_pwd_unlock
    import serial_unlock_pkg::*;
#(
    parameter int                 PWD_LEN        = 4,
    parameter logic [PWD_LEN-1:0] DEFAULT_PWD    = 4'b1011,
    parameter int                 MAX_ATTEMPTS   = 3,
    parameter int                 LOCKOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               serial_valid,
    input  logic               serial_data,
    output logic               serial_ready,
    input  logic               pwd_load,
    input  logic [PWD_LEN-1:0] pwd_value,
    output logic               unlock,
    output logic               pwd_incorrect,
    output logic               locked_out
);

    localparam int             BW       = bit_cnt_width(PWD_LEN);
    localparam logic [BW-1:0]  LAST_IDX = BW'(PWD_LEN - 1);

    unlock_state_t      r_state, w_state_next;
    logic [BW-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic               r_mismatch, w_mismatch_next;
    logic [PWD_LEN-1:0] r_pwd, w_pwd_next;

    logic          w_locked;
    logic          w_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_bit_match;
    logic [BW-1:0] w_bit_idx;
    logic          w_unlock;
    logic          w_incorrect;
    logic          w_lock_enter;
    logic          w_lock_exit;

`ifdef SERIAL_UNLOCK_LOCKOUT_EN
    localparam int AW = attempt_width(MAX_ATTEMPTS);
    localparam int TW = timer_width(LOCKOUT_CYCLES);

    logic [AW-1:0] r_attempts, w_attempts_next;
    logic          w_timer_done;

    serial_unlock_lockout_timer #(
        .W (TW)
    ) u_lockout_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_lock_enter),
        .load_value (TW'(LOCKOUT_CYCLES - 1)),
        .done       (w_timer_done)
    );

    // The failing verdict that reaches MAX_ATTEMPTS sends us into lockout.
    assign w_lock_enter = w_incorrect && (r_attempts == AW'(MAX_ATTEMPTS - 1));
    assign w_lock_exit  = w_timer_done;
    assign w_locked     = (r_state == LOCKOUT);

    // Consecutive-failure count: cleared by a match or by leaving lockout.
    always_comb begin
        w_attempts_next = r_attempts;
        if (r_state == LOCKOUT && w_timer_done) begin
            w_attempts_next = '0;
        end else if (w_unlock) begin
            w_attempts_next = '0;
        end else if (w_incorrect) begin
            w_attempts_next = r_attempts + 1'b1;
        end
    end

    // Attempt counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_attempts <= '0;
        end else begin
            r_attempts <= w_attempts_next;
        end
    end
`else
    // Unlimited retries: LOCKOUT is never entered, and if it were it exits at once.
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_ATTEMPTS > 0) ^ (LOCKOUT_CYCLES > 0);
    assign w_lock_enter = 1'b0;
    assign w_lock_exit  = 1'b1;
    assign w_locked     = 1'b0;
`endif

    assign w_ready     = !reset && !w_locked && !pwd_load;
    assign w_accept    = serial_valid && w_ready;
    assign w_last      = (r_bit_cnt == LAST_IDX);
    assign w_bit_idx   = LAST_IDX - r_bit_cnt;
    assign w_bit_match = (serial_data == r_pwd[w_bit_idx]);
    // bit_cnt is 0 in IDLE and PWD_LEN >= 2, so w_last only fires in COLLECT.
    assign w_unlock    = w_accept && w_last && !r_mismatch && w_bit_match;
    assign w_incorrect = w_accept && w_last && (r_mismatch || !w_bit_match);

    // Next-state logic: password load aborts a frame, each accepted bit
    // advances it, the last bit returns to IDLE (or LOCKOUT on the final failure).
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_mismatch_next = r_mismatch;
        w_pwd_next      = r_pwd;
        case (r_state)
            IDLE, COLLECT: begin
                if (pwd_load) begin
                    w_pwd_next      = pwd_value;
                    w_state_next    = IDLE;
                    w_bit_cnt_next  = '0;
                    w_mismatch_next = 1'b0;
                end else if (w_accept) begin
                    if (w_last) begin
                        w_state_next    = w_lock_enter ? LOCKOUT : IDLE;
                        w_bit_cnt_next  = '0;
                        w_mismatch_next = 1'b0;
                    end else begin
                        w_state_next    = COLLECT;
                        w_bit_cnt_next  = r_bit_cnt + 1'b1;
                        w_mismatch_next = r_mismatch || !w_bit_match;
                    end
                end
            end
            LOCKOUT: begin
                if (w_lock_exit) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_bit_cnt_next  = '0;
                w_mismatch_next = 1'b0;
            end
        endcase
    end

    // State and frame registers; reset restores the default password.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_mismatch <= 1'b0;
            r_pwd      <= DEFAULT_PWD;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_mismatch <= w_mismatch_next;
            r_pwd      <= w_pwd_next;
        end
    end

    assign serial_ready  = w_ready;
    assign unlock        = w_unlock;
    assign pwd_incorrect = w_incorrect;
    assign locked_out    = w_locked;

endmodule

// File: tb/tb_serial_pwd_unlock.sv
// Directed self-checking bench for serial_pwd_unlock (default and 8-bit builds).
// Lockout scenarios are exercised when SERIAL_UNLOCK_LOCKOUT_EN is defined.
module tb_serial_pwd_unlock;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_valid = 1'b0;
    logic       serial_data = 1'b0;
    logic       serial_ready;
    logic       pwd_load = 1'b0;
    logic [3:0] pwd_value = 4'h0;
    logic       unlock;
    logic       pwd_incorrect;
    logic       locked_out;

    logic       v8 = 1'b0;
    logic       d8 = 1'b0;
    logic       rdy8;
    logic       ld8 = 1'b0;
    logic [7:0] pv8 = 8'h00;
    logic       u8;
    logic       i8;
    logic       lo8;

    int         n_tests = 0;
    int         n_fail = 0;
    logic       exp_locked = 1'b0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    serial_pwd_unlock dut (
        .clk           (clk),
        .reset         (reset),
        .serial_valid  (serial_valid),
        .serial_data   (serial_data),
        .serial_ready  (serial_ready),
        .pwd_load      (pwd_load),
        .pwd_value     (pwd_value),
        .unlock        (unlock),
        .pwd_incorrect (pwd_incorrect),
        .locked_out    (locked_out)
    );

    serial_pwd_unlock #(
        .PWD_LEN     (8),
        .DEFAULT_PWD (8'hA5)
    ) dut8 (
        .clk           (clk),
        .reset         (reset),
        .serial_valid  (v8),
        .serial_data   (d8),
        .serial_ready  (rdy8),
        .pwd_load      (ld8),
        .pwd_value     (pv8),
        .unlock        (u8),
        .pwd_incorrect (i8),
        .locked_out    (lo8)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; expected verdict is queued when a handshake is
    // expected and retired when the DUT actually takes the bit.
    task automatic step(input logic v, input logic d, input logic ld, input logic [3:0] pv,
                        input logic exp_rdy, input logic exp_u, input logic exp_i, input string tag);
        logic [1:0] e;
        @(posedge clk);
        #1;
        serial_valid = v;
        serial_data  = d;
        pwd_load     = ld;
        pwd_value    = pv;
        if (v && exp_rdy) sb.push_back({exp_u, exp_i});
        @(negedge clk);
        check({tag, "_rdy"}, serial_ready, exp_rdy);
        check({tag, "_lock"}, locked_out, exp_locked);
        if (serial_valid && serial_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL %s_sb: observed unexpected handshake expected none", tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_unlock"}, unlock, e[1]);
                check({tag, "_incorrect"}, pwd_incorrect, e[0]);
            end
        end else begin
            check({tag, "_unlock_idle"}, unlock, 1'b0);
            check({tag, "_incorrect_idle"}, pwd_incorrect, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [3:0] bits, input logic eu, input logic ei,
                              input logic gap, input string tag);
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, bits[k], 1'b0, 4'h0, 1'b1, (k == 0) ? eu : 1'b0, (k == 0) ? ei : 1'b0, tag);
            if (gap) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, {tag, "_gap"});
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            reset        = 1'b1;
            serial_valid = 1'b1;
            serial_data  = 1'b1;
            pwd_load     = 1'b0;
            @(negedge clk);
            check("rst_rdy", serial_ready, 1'b0);
            check("rst_unlock", unlock, 1'b0);
            check("rst_incorrect", pwd_incorrect, 1'b0);
        end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        serial_valid = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", serial_ready, 1'b1);
        check("post_rst_unlock", unlock, 1'b0);
        check("post_rst_incorrect", pwd_incorrect, 1'b0);
        check("post_rst_lock", locked_out, 1'b0);
        check("post_rst_rdy8", rdy8, 1'b1);
    endtask

    task automatic send_frame8(input logic [7:0] bits, input logic eu, input logic ei, input string tag);
        for (int k = 7; k >= 0; k--) begin
            @(posedge clk);
            #1;
            v8 = 1'b1;
            d8 = bits[k];
            @(negedge clk);
            check({tag, "_rdy"}, rdy8, 1'b1);
            check({tag, "_unlock"}, u8, (k == 0) ? eu : 1'b0);
            check({tag, "_incorrect"}, i8, (k == 0) ? ei : 1'b0);
            check({tag, "_lock"}, lo8, 1'b0);
        end
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    initial begin
        // 1: reset, correct default password with idle gaps
        do_reset(2);
        send_frame(4'b1011, 1'b1, 1'b0, 1'b1, "t1_ok");

        // 2: wrong frame, then correct frame back-to-back
        send_frame(4'b1001, 1'b0, 1'b1, 1'b0, "t2_bad");
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, "t2_ok");

`ifdef SERIAL_UNLOCK_LOCKOUT_EN
        // attempt counter was cleared: two more failures must not lock out
        send_frame(4'b0000, 1'b0, 1'b1, 1'b0, "t2_bad_a");
        send_frame(4'b0000, 1'b0, 1'b1, 1'b0, "t2_bad_b");
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, "t2_clear");

        // 3: three failures lock out for 16 cycles; bits and loads ignored
        send_frame(4'b0000, 1'b0, 1'b1, 1'b0, "t3_bad1");
        send_frame(4'b0000, 1'b0, 1'b1, 1'b0, "t3_bad2");
        send_frame(4'b0000, 1'b0, 1'b1, 1'b0, "t3_bad3");
        exp_locked = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b1, (c == 5), 4'h0, 1'b0, 1'b0, 1'b0, "t3_lock");
        end
        exp_locked = 1'b0;
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, "t3_after");
`else
        // 6: unlimited retries without lockout
        for (int f = 0; f < 5; f++) begin
            send_frame(4'b0000, 1'b0, 1'b1, 1'b0, "t6_bad");
        end
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, "t6_ok");
`endif

        // 4: load aborts a partial frame, then new password is used
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "t4_b0");
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "t4_b1");
        step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, "t4_load");
        send_frame(4'b0110, 1'b1, 1'b0, 1'b0, "t4_new_ok");
        send_frame(4'b1011, 1'b0, 1'b1, 1'b0, "t4_old_bad");

        // 5: reset mid-frame restores the default password
        step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, "t5_load");
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "t5_b0");
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "t5_b1");
        do_reset(2);
        send_frame(4'b1011, 1'b1, 1'b0, 1'b0, "t5_default");

        // 6b: 8-bit instance with default 8'hA5
        send_frame8(8'hA5, 1'b1, 1'b0, "t6_p8_ok");
        send_frame8(8'hA4, 1'b0, 1'b1, "t6_p8_bad");
        send_frame8(8'hA5, 1'b1, 1'b0, "t6_p8_ok2");

        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, "final_idle");
        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
